aes256_key_schedule: RTL and testbench

Sequential AES-256 key-schedule controller. It accepts a 256-bit cipher key and iterates the combinational one-round expand-key stage once per clock to produce all 15 round keys. Results go into an internal 15×128-bit round-key file. It sits between the key-load interface and the round datapath, which reads round keys by index and may start as soon as the keys it needs are flagged available.

---
 rtl/aes256_key_schedule.sv | 135 +++++++++++++
 tb/tb_aes256_key_schedule.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_key_schedule.sv
// AES-256 key-schedule controller: one expand-key round per clock fills a 15-entry
// round-key file, with a per-key valid mask so the round datapath can start early.

module aes256_expand_stage (
    input  logic [255:0] state,
    input  logic [3:0]   rnd,
    output logic [127:0] out,
    output logic [255:0] next
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [31:0] temp, o0, o1, o2, o3;
    logic [7:0]  rcon;

    always_comb begin
        case (rnd[3:1])
            3'd1:    rcon = 8'h01;
            3'd2:    rcon = 8'h02;
            3'd3:    rcon = 8'h04;
            3'd4:    rcon = 8'h08;
            3'd5:    rcon = 8'h10;
            3'd6:    rcon = 8'h20;
            3'd7:    rcon = 8'h40;
            default: rcon = 8'h00;
        endcase
        // Even round keys start a new 8-word group (RotWord + Rcon); odd ones only SubWord.
        if (!rnd[0])
            temp = sub_word({state[23:0], state[31:24]}) ^ {rcon, 24'h000000};
        else
            temp = sub_word(state[31:0]);
        o0   = state[255:224] ^ temp;
        o1   = state[223:192] ^ o0;
        o2   = state[191:160] ^ o1;
        o3   = state[159:128] ^ o2;
        out  = {o0, o1, o2, o3};
        next = {state[127:0], o0, o1, o2, o3};
    end
endmodule

module aes256_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [255:0] key_in,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [14:0]  rk_mask,
    input  logic         rd_en,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_data
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} fsm_t;

    fsm_t         fsm;
    logic [255:0] state;
    logic [3:0]   rnd;
    logic [127:0] key_file [0:14];
    logic [127:0] rk_out;
    logic [255:0] state_next;
    logic         accept, expand_we;

    aes256_expand_stage u_stage (
        .state (state),
        .rnd   (rnd),
        .out   (rk_out),
        .next  (state_next)
    );

    assign key_ready = (fsm != EXPAND);
    assign busy      = (fsm == EXPAND);
    assign done      = (fsm == DONE);
    assign accept    = key_valid & key_ready & ~flush;
    assign expand_we = (fsm == EXPAND) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm     <= IDLE;
            state   <= '0;
            rnd     <= '0;
            rk_mask <= '0;
        end else if (flush) begin
            fsm     <= IDLE;
            rnd     <= '0;
            rk_mask <= '0;
        end else if (accept) begin
            fsm     <= EXPAND;
            state   <= key_in;
            rnd     <= 4'd2;
            rk_mask <= 15'h0003;
        end else if (fsm == EXPAND) begin
            state   <= state_next;
            rk_mask <= rk_mask | (15'd1 << rnd);
            if (rnd == 4'd14)
                fsm <= DONE;
            else
                rnd <= rnd + 4'd1;
        end
    end

    // Key file is not reset; rk_mask alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            key_file[0] <= key_in[255:128];
            key_file[1] <= key_in[127:0];
        end else if (expand_we) begin
            key_file[rnd] <= rk_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= (rd_addr <= 4'd14) ? key_file[rd_addr] : '0;
    end
endmodule

// File: tb/tb_aes256_key_schedule.sv
// Bench for aes256_key_schedule: independent key-expansion model (S-box derived from
// GF(2^8) inversion), read scoreboard, and a table of fixed read vectors.

module tb_aes256_key_schedule;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key_in;
    logic         flush;
    logic         busy;
    logic         done;
    logic [14:0]  rk_mask;
    logic         rd_en;
    logic [3:0]   rd_addr;
    logic [127:0] rd_data;

    aes256_key_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .rk_mask   (rk_mask),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] exp;
        string        name;
    } rd_vec_t;

    typedef struct {
        logic [127:0] exp;
        string        name;
    } sb_t;

    int           checks = 0;
    int           failures = 0;
    sb_t          sbq[$];
    logic [7:0]   sb [256];
    logic [127:0] exp_rk [6][15];
    rd_vec_t      vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a  = a << 1;
            if (hi) a ^= 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    task automatic model_expand(input int s, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++)
            exp_rk[s][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    task automatic issue_read(input logic [3:0] a, input logic [127:0] exp, input string name);
        sb_t e;
        e.exp = exp;
        e.name = name;
        sbq.push_back(e);
        rd_en = 1'b1;
        rd_addr = a;
    endtask

    task automatic tick();
        logic fire;
        sb_t  e;
        fire = rd_en;
        @(posedge clk);
        #1;
        if (fire) begin
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: got read with no expected entry");
            end else begin
                e = sbq.pop_front();
                check(e.name, rd_data, e.exp);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"}, 128'(key_ready), 128'd1);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_done"}, 128'(done), 128'd0);
        check({tag, "_rk_mask"}, 128'(rk_mask), 128'd0);
        check({tag, "_rd_data"}, rd_data, 128'd0);
    endtask

    task automatic rand_key(output logic [255:0] k);
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    endtask

    initial begin
        logic [255:0] ka, kb, kc, kd, ke, kf;
        rst_n = 1'b0;
        key_valid = 1'b0;
        key_in = '0;
        flush = 1'b0;
        rd_en = 1'b0;
        rd_addr = '0;

        build_sbox();
        ka = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        kb = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        rand_key(kc);
        rand_key(kd);
        rand_key(ke);
        rand_key(kf);
        model_expand(0, ka);
        model_expand(1, kb);
        model_expand(2, kc);
        model_expand(3, kd);
        model_expand(4, ke);
        model_expand(5, kf);

        vecs[0] = '{4'd15, 128'h0, "rdA_addr15"};
        vecs[1] = '{4'd0, 128'h000102030405060708090a0b0c0d0e0f, "rdA_0"};
        vecs[2] = '{4'd2, 128'ha573c29fa176c498a97fce93a572c09c, "rdA_2"};
        vecs[3] = '{4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "rdA_14"};
        vecs[4] = '{4'd1, exp_rk[0][1], "rdA_1"};
        vecs[5] = '{4'd9, exp_rk[0][9], "rdA_9"};

        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Key A: poll mask every cycle and read each key the cycle after it appears.
        key_in = ka;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check("A_accept_mask", 128'(rk_mask), 128'h3);
        check("A_accept_busy", 128'(busy), 128'd1);
        check("A_accept_ready", 128'(key_ready), 128'd0);
        for (int j = 1; j <= 13; j++) begin
            tick();
            check($sformatf("A_mask_c%0d", j), 128'(rk_mask), 128'((1 << (j + 2)) - 1));
            check($sformatf("A_done_c%0d", j), 128'(done), 128'(j == 13));
            issue_read(4'(j + 1), exp_rk[0][j + 1], $sformatf("A_early_rk%0d", j + 1));
        end
        tick();
        check("A_done_ready", 128'(key_ready), 128'd1);

        for (int i = 0; i < 6; i++) begin
            issue_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
            tick();
        end
        tick();
        check("rd_hold", rd_data, exp_rk[0][9]);

        // Key B accepted from DONE; key C held valid throughout B's expansion.
        key_in = kb;
        key_valid = 1'b1;
        tick();
        check("B_accept_mask", 128'(rk_mask), 128'h3);
        key_in = kc;
        for (int j = 1; j <= 13; j++) begin
            tick();
            check($sformatf("B_ready_c%0d", j), 128'(key_ready), 128'(j == 13));
            check($sformatf("B_done_c%0d", j), 128'(done), 128'(j == 13));
        end
        issue_read(4'd14, exp_rk[1][14], "B_rk14");
        tick();
        key_valid = 1'b0;
        check("C_accept_mask", 128'(rk_mask), 128'h3);
        check("C_accept_busy", 128'(busy), 128'd1);
        repeat (13) tick();
        check("C_done", 128'(done), 128'd1);
        issue_read(4'd0, exp_rk[2][0], "C_rk0");
        tick();
        issue_read(4'd8, exp_rk[2][8], "C_rk8");
        tick();
        issue_read(4'd14, exp_rk[2][14], "C_rk14");
        tick();

        // Key D flushed in round 7 while key E is offered; E accepted one cycle later.
        key_in = kd;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (5) tick();
        check("D_mask_rnd7", 128'(rk_mask), 128'h7f);
        flush = 1'b1;
        key_valid = 1'b1;
        key_in = ke;
        tick();
        flush = 1'b0;
        check("flush_mask", 128'(rk_mask), 128'd0);
        check("flush_done", 128'(done), 128'd0);
        check("flush_busy", 128'(busy), 128'd0);
        check("flush_ready", 128'(key_ready), 128'd1);
        tick();
        key_valid = 1'b0;
        check("E_accept_mask", 128'(rk_mask), 128'h3);
        for (int j = 1; j <= 13; j++) begin
            tick();
            if (j == 3) begin
                check("E_mask_before_rk5", 128'(rk_mask), 128'h1f);
                issue_read(4'd5, exp_rk[3][5], "samecycle_old_rk5");
            end
            if (j == 4) issue_read(4'd5, exp_rk[4][5], "samecycle_new_rk5");
        end
        check("E_done", 128'(done), 128'd1);
        check("E_mask_full", 128'(rk_mask), 128'h7fff);
        issue_read(4'd14, exp_rk[4][14], "E_rk14");
        tick();

        // Asynchronous reset partway through key F.
        key_in = kf;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        issue_read(4'd0, exp_rk[5][0], "F_rk0");
        tick();
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("async_rst");
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_mask", 128'(rk_mask), 128'd0);
        check("post_rst_busy", 128'(busy), 128'd0);
        issue_read(4'd15, 128'h0, "post_rst_addr15");
        tick();
        key_in = ka;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check("restart_mask", 128'(rk_mask), 128'h3);
        repeat (12) tick();
        check("restart_not_done", 128'(done), 128'd0);
        tick();
        check("restart_done", 128'(done), 128'd1);
        check("restart_mask_full", 128'(rk_mask), 128'h7fff);
        issue_read(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "restart_rk14");
        tick();

        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
